// File: rtl/cpu_exec_scheduler_pkg.sv
// cpu_exec_scheduler_pkg: shared state encoding for the CPU execution scheduler.
//   sched_state_t: HALT=00, RUN=01, STEP=10, BREAK=11 (visible on sched_state).
package cpu_exec_scheduler_pkg;
  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } sched_state_t;
endpackage

// File: rtl/cpu_exec_scheduler_prescaler.sv
// cpu_exec_scheduler_prescaler: DIV_W-bit rate counter with selectable terminal count.
//   clk, resetn (async active-low), clear (sync zero), count_en (advance),
//   fast (1: DIV_FAST, 0: DIV_SLOW), terminal (count >= selected divide - 1).
module cpu_exec_scheduler_prescaler #(
  parameter int DIV_SLOW = 25_000_000,
  parameter int DIV_FAST = 2_500_000,
  parameter int DIV_W    = 25
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic count_en,
  input  logic fast,
  output logic terminal
);
  localparam logic [DIV_W-1:0] LAST_SLOW = DIV_W'(DIV_SLOW - 1);
  localparam logic [DIV_W-1:0] LAST_FAST = DIV_W'(DIV_FAST - 1);
  logic [DIV_W-1:0] count;
  // >= rather than == so a rate switch to a shorter period never wraps through 2^DIV_W
  assign terminal = count >= (fast ? LAST_FAST : LAST_SLOW);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) count <= '0;
    else if (clear) count <= '0;
    else if (count_en) count <= terminal ? '0 : count + 1'b1;
endmodule

// File: rtl/cpu_exec_scheduler.sv
// cpu_exec_scheduler: single-cycle CPU execution enable (halt / run slow|turbo / step / breakpoint).
//   clk, resetn (async active-low); run_toggle, step_req: one-cycle button pulses;
//   turbo: rate select; instruction_pointer, bp_addr, bp_valid: breakpoint compare;
//   enable: registered one-cycle CPU enable; sched_state: current state; bp_hit: 1 while in BREAK.
//   Define CPU_SCHED_BREAKPOINT_EN to build the breakpoint compare and BREAK state;
//   otherwise the breakpoint inputs are ignored and bp_hit is 0.
module cpu_exec_scheduler
  import cpu_exec_scheduler_pkg::*;
#(
  parameter int DIV_SLOW = 25_000_000,
  parameter int DIV_FAST = 2_500_000,
  parameter int DIV_W    = 25
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run_toggle,
  input  logic       step_req,
  input  logic       turbo,
  input  logic [7:0] instruction_pointer,
  input  logic [7:0] bp_addr,
  input  logic       bp_valid,
  output logic       enable,
  output logic [1:0] sched_state,
  output logic       bp_hit
);
  sched_state_t state;
  logic terminal;
  assign sched_state = state;
  // Held clear outside RUN, so every entry into RUN starts a full period
  cpu_exec_scheduler_prescaler #(
    .DIV_SLOW(DIV_SLOW),
    .DIV_FAST(DIV_FAST),
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk(clk),
    .resetn(resetn),
    .clear(state != S_RUN),
    .count_en(1'b1),
    .fast(turbo),
    .terminal(terminal)
  );
`ifdef CPU_SCHED_BREAKPOINT_EN
  // resume_skip lets the first pulse after resuming execute the breakpointed instruction
  logic resume_skip;
  logic bp_match;
  assign bp_match = bp_valid && instruction_pointer == bp_addr && !resume_skip;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state       <= S_HALT;
      enable      <= 1'b0;
      bp_hit      <= 1'b0;
      resume_skip <= 1'b0;
    end else begin
      enable <= 1'b0;
      case (state)
        S_HALT:
          if (run_toggle) state <= S_RUN;
          else if (step_req) state <= S_STEP;
        S_STEP: begin
          enable      <= 1'b1;
          resume_skip <= 1'b0;
          state       <= S_HALT;
        end
        S_RUN:
          if (run_toggle) state <= S_HALT;
          else if (terminal && bp_match) begin
            state  <= S_BREAK;
            bp_hit <= 1'b1;
          end else if (terminal) begin
            enable      <= 1'b1;
            resume_skip <= 1'b0;
          end
        S_BREAK:
          if (run_toggle) begin
            state       <= S_RUN;
            resume_skip <= 1'b1;
            bp_hit      <= 1'b0;
          end else if (step_req) begin
            state  <= S_STEP;
            bp_hit <= 1'b0;
          end
        default: state <= S_HALT;
      endcase
    end
`else
  logic unused_bp;
  assign unused_bp = ^{instruction_pointer, bp_addr, bp_valid};
  assign bp_hit = 1'b0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state  <= S_HALT;
      enable <= 1'b0;
    end else begin
      enable <= 1'b0;
      case (state)
        S_HALT:
          if (run_toggle) state <= S_RUN;
          else if (step_req) state <= S_STEP;
        S_STEP: begin
          enable <= 1'b1;
          state  <= S_HALT;
        end
        S_RUN:
          if (run_toggle) state <= S_HALT;
          else if (terminal) enable <= 1'b1;
        default: state <= S_HALT;
      endcase
    end
`endif
endmodule
